// File: rtl/rx_det_sched.sv
`timescale 1ns/1ps
// Receiver-detect scheduler: runs the shared detect circuit lane by lane, two passes, over a req/ack handshake.
// 5+SETTLE_CYCLES cycles per lane with a one-cycle ack; bounded by ACK_TIMEOUT per phase, abort/start are level/pulse inputs with no backpressure.
module rx_det_sched #(
  parameter int NUM_LANES     = 4,
  parameter int ACK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [NUM_LANES-1:0] rx_det_seq_req,
  input  logic [NUM_LANES-1:0] rx_det_seq_ack,
  input  logic [NUM_LANES-1:0] rx_det,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LANES-1:0] det_mask,
  output logic [NUM_LANES-1:0] timeout_err
);

  localparam int CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [CW-1:0] TO_LAST     = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_REL    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state;
  logic [LW-1:0]        lane;
  logic                 pass;
  logic [CW-1:0]        cnt;
  logic [NUM_LANES-1:0] p0_mask;
  logic [NUM_LANES-1:0] p1_mask;
  logic [NUM_LANES-1:0] err;

  logic [NUM_LANES-1:0] p1_elig;
  logic [NUM_LANES-1:0] cur_elig;
  logic                 nxt_found;
  logic [LW-1:0]        nxt_lane;
  logic                 first_found;
  logic [LW-1:0]        first_lane;

  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LW-1:0] idx);
    logic [NUM_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Descending scan so the lowest qualifying lane is the one that sticks.
  always_comb begin
    p1_elig     = p0_mask & ~err;
    cur_elig    = pass ? p1_elig : '1;
    nxt_found   = 1'b0;
    nxt_lane    = '0;
    first_found = 1'b0;
    first_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (cur_elig[i] && (LW'(i) > lane)) begin
        nxt_found = 1'b1;
        nxt_lane  = LW'(i);
      end
      if (p1_elig[i]) begin
        first_found = 1'b1;
        first_lane  = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      lane           <= '0;
      pass           <= 1'b0;
      cnt            <= '0;
      p0_mask        <= '0;
      p1_mask        <= '0;
      err            <= '0;
      rx_det_seq_req <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      det_mask       <= '0;
      timeout_err    <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rx_det_seq_req <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      det_mask       <= '0;
      timeout_err    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state          <= S_REQ;
            lane           <= '0;
            pass           <= 1'b0;
            cnt            <= '0;
            p0_mask        <= '0;
            p1_mask        <= '0;
            err            <= '0;
            det_mask       <= '0;
            timeout_err    <= '0;
            rx_det_seq_req <= lane_bit('0);
            busy           <= 1'b1;
          end
        end

        S_REQ: begin
          if (rx_det_seq_ack[lane]) begin
            state          <= S_REL;
            rx_det_seq_req <= '0;
            cnt            <= '0;
          end else if (cnt == TO_LAST) begin
            err[lane]      <= 1'b1;
            rx_det_seq_req <= '0;
            state          <= S_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REL: begin
          if (!rx_det_seq_ack[lane]) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            err[lane] <= 1'b1;
            state     <= S_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            if (pass) p1_mask[lane] <= rx_det[lane];
            else      p0_mask[lane] <= rx_det[lane];
            state <= S_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_NEXT: begin
          cnt <= '0;
          if (nxt_found) begin
            lane           <= nxt_lane;
            rx_det_seq_req <= lane_bit(nxt_lane);
            state          <= S_REQ;
          end else if (!pass && first_found) begin
            pass           <= 1'b1;
            lane           <= first_lane;
            rx_det_seq_req <= lane_bit(first_lane);
            state          <= S_REQ;
          end else begin
            // Result lands on the same edge that raises done.
            state       <= S_DONE;
            done        <= 1'b1;
            det_mask    <= p0_mask & p1_mask & ~err;
            timeout_err <= err;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state          <= S_IDLE;
          rx_det_seq_req <= '0;
          busy           <= 1'b0;
          done           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_det_sched.sv
`timescale 1ns/1ps
// Bench for rx_det_sched: lane-level timeline model, per-cycle compare, directed and random runs.
module tb_rx_det_sched;

  localparam int NL   = 4;
  localparam int AT   = 64;
  localparam int SC   = 16;
  localparam int MAXK = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_drv = 1'b0;
  logic          abort_drv = 1'b0;
  logic          start, abort;
  logic [NL-1:0] req, ack, rx_det, det_mask, timeout_err;
  logic          busy, done;

  // Scenario: per-lane mode (0 normal, 1 never acks, 2 ack never released), ack delay, detect patterns.
  int            md [NL];
  int            dl [NL];
  logic [NL-1:0] p0_pat, p1_pat;

  int   nk = 0, pass1_start = MAXK, t_done = 0, t_end = 0, ab_k = 0, sb_k = 0;
  logic ab_en = 1'b0, sb_en = 1'b0, chk_en = 1'b0, clr_stuck = 1'b1;
  logic [NL-1:0] mdl_det, mdl_err;

  logic [NL-1:0] exp_req  [MAXK];
  logic          exp_busy [MAXK];
  logic          exp_done [MAXK];
  logic [NL-1:0] exp_det  [MAXK];
  logic [NL-1:0] exp_terr [MAXK];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  // nk is the index of the next edge relative to the start edge.
  assign start  = start_drv | (sb_en && (nk == sb_k));
  assign abort  = abort_drv | (ab_en && (nk == ab_k));
  assign rx_det = (nk < pass1_start) ? p0_pat : p1_pat;

  rx_det_sched #(.NUM_LANES(NL), .ACK_TIMEOUT(AT), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rx_det_seq_req(req), .rx_det_seq_ack(ack), .rx_det(rx_det),
    .busy(busy), .done(done), .det_mask(det_mask), .timeout_err(timeout_err)
  );

  // Analog-side responder: ack follows req through a dl-stage register pipe.
  logic [2:0]    pipe [NL];
  logic [NL-1:0] stuck;

  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (clr_stuck) begin
        pipe[i]  <= '0;
        stuck[i] <= 1'b0;
      end else begin
        pipe[i] <= {pipe[i][1:0], req[i]};
        if (md[i] == 2 && pipe[i][dl[i]-1]) stuck[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NL; i++)
      ack[i] = (md[i] == 1) ? 1'b0 : (pipe[i][dl[i]-1] | stuck[i]);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, expv);
    end
  endtask

  // Timeline model: each lane test is a fixed-length slot derived from its ack behaviour.
  task automatic build_model(input int ab);
    int t, hi;
    logic [NL-1:0] err, m0, m1, elig;
    for (int k = 0; k < MAXK; k++) begin
      exp_req[k] = '0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
      exp_det[k] = '0; exp_terr[k] = '0;
    end
    t = 0; err = '0; m0 = '0; m1 = '0; pass1_start = MAXK;
    for (int p = 0; p < 2; p++) begin
      elig = (p == 0) ? '1 : (m0 & ~err);
      if (p == 1 && elig != '0) pass1_start = t;
      for (int l = 0; l < NL; l++) begin
        if (elig[l]) begin
          hi = (md[l] == 1) ? AT + 1 : dl[l] + 1;
          for (int k = t; k < t + hi; k++) exp_req[k][l] = 1'b1;
          if (md[l] == 1) begin
            err[l] = 1'b1; t += AT + 2;
          end else if (md[l] == 2) begin
            err[l] = 1'b1; t += dl[l] + 1 + (AT + 1) + 1;
          end else begin
            if (p == 0) m0[l] = p0_pat[l];
            else        m1[l] = p1_pat[l];
            t += 2 * dl[l] + 2 + SC + 1;
          end
        end
      end
    end
    t_done  = t;
    mdl_det = m0 & m1 & ~err;
    mdl_err = err;
    for (int k = 0; k < MAXK; k++) begin
      exp_busy[k] = (k <= t_done);
      exp_done[k] = (k == t_done);
      exp_det[k]  = (k >= t_done) ? mdl_det : '0;
      exp_terr[k] = (k >= t_done) ? mdl_err : '0;
      if (ab > 0 && k >= ab) begin
        exp_req[k] = '0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
        exp_det[k] = '0; exp_terr[k] = '0;
      end
    end
    t_end = ((ab > 0) ? ab : t_done + 1) + 3;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (nk < MAXK) begin
        chk("req", nk, 32'(req), 32'(exp_req[nk]));
        chk("busy", nk, 32'(busy), 32'(exp_busy[nk]));
        chk("done", nk, 32'(done), 32'(exp_done[nk]));
        chk("det_mask", nk, 32'(det_mask), 32'(exp_det[nk]));
        chk("timeout_err", nk, 32'(timeout_err), 32'(exp_terr[nk]));
      end
      nk = nk + 1;
    end
  end

  task automatic run(input int ab, input int sbk);
    build_model(ab);
    @(negedge clk); clr_stuck = 1'b1;
    @(negedge clk); clr_stuck = 1'b0;
    ab_en = (ab > 0); ab_k = ab;
    sb_en = (sbk > 0); sb_k = sbk;
    nk = 0; start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0; chk_en = 1'b1;
    repeat (t_end + 2) @(negedge clk);
    #1 chk_en = 1'b0; ab_en = 1'b0; sb_en = 1'b0;
  endtask

  function automatic int req_cycles(input int l);
    int c = 0;
    for (int k = 0; k < MAXK; k++) if (exp_req[k][l]) c++;
    return c;
  endfunction

  task automatic set_default();
    for (int i = 0; i < NL; i++) begin md[i] = 0; dl[i] = 1; end
  endtask

  initial begin
    int ab, sbk;
    set_default();
    p0_pat = '0; p1_pat = '0;
    #1 rst = 1'b0;
    #11;
    chk("rst_req", -1, 32'(req), 0);
    chk("rst_busy", -1, 32'(busy), 0);
    chk("rst_done", -1, 32'(done), 0);
    chk("rst_det", -1, 32'(det_mask), 0);
    chk("rst_terr", -1, 32'(timeout_err), 0);
    @(negedge clk) rst = 1'b1;

    // All lanes detected.
    p0_pat = 4'b1111; p1_pat = 4'b1111;
    run(0, 0);
    chk("tdone_all", -1, t_done, 168);
    chk("det_all", -1, 32'(det_mask), 32'h0000000f);
    chk("terr_all", -1, 32'(timeout_err), 0);

    // Alternate lanes: pass 1 only revisits 0 and 2.
    p0_pat = 4'b0101; p1_pat = 4'b0101;
    run(0, 0);
    chk("tdone_0101", -1, t_done, 126);
    chk("req1_cycles_0101", -1, req_cycles(1), 2);
    chk("det_0101", -1, 32'(det_mask), 32'h5);

    // Lane 2 never acks.
    md[2] = 1; p0_pat = 4'b1111; p1_pat = 4'b1111;
    run(0, 0);
    chk("tdone_dead2", -1, t_done, 192);
    chk("req2_cycles_dead2", -1, req_cycles(2), 65);
    chk("det_dead2", -1, 32'(det_mask), 32'hb);
    chk("terr_dead2", -1, 32'(timeout_err), 32'h4);
    set_default();

    // Nothing detected: pass 1 skipped.
    p0_pat = 4'b0000; p1_pat = 4'b0000;
    run(0, 0);
    chk("tdone_none", -1, t_done, 84);
    chk("det_none", -1, 32'(det_mask), 0);

    // Lane 1 lost in pass 1, plus a start pulse while busy.
    p0_pat = 4'b1111; p1_pat = 4'b1101;
    run(0, 100);
    chk("det_lane1_lost", -1, 32'(det_mask), 32'hd);

    // Abort inside lane 1 settle window, then a clean rerun.
    p0_pat = 4'b1111; p1_pat = 4'b1111;
    run(31, 0);
    chk("det_after_abort", -1, 32'(det_mask), 0);
    run(0, 0);
    chk("det_rerun", -1, 32'(det_mask), 32'hf);

    // start and abort together while idle.
    @(negedge clk); start_drv = 1'b1; abort_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0; abort_drv = 1'b0;
    chk("sa_idle_busy", -1, 32'(busy), 0);
    chk("sa_idle_req", -1, 32'(req), 0);
    @(negedge clk);
    chk("sa_idle_busy2", -1, 32'(busy), 0);

    // Randomized scenarios.
    for (int it = 0; it < 40; it++) begin
      p0_pat = 4'($urandom);
      p1_pat = ($urandom_range(0, 1) == 1) ? p0_pat : 4'($urandom);
      for (int i = 0; i < NL; i++) begin
        int r;
        r = $urandom_range(0, 9);
        md[i] = (r == 0) ? 1 : (r == 1) ? 2 : 0;
        dl[i] = $urandom_range(1, 3);
      end
      build_model(0);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, t_done) : 0;
      sbk = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (ab == 0) sbk = $urandom_range(1, t_done);
        else if (ab > 1) sbk = $urandom_range(1, ab - 1);
      end
      run(ab, sbk);
      if (ab == 0) chk("rand_det_idle", it, 32'(det_mask), 32'(mdl_det));
    end
    set_default();

    // Asynchronous reset in the middle of lane 0 REQ.
    p0_pat = 4'b1111; p1_pat = 4'b1111;
    @(negedge clk); nk = 0; start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    chk("req_before_rst", -1, 32'(req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", -1, 32'(req), 0);
    chk("arst_busy", -1, 32'(busy), 0);
    chk("arst_done", -1, 32'(done), 0);
    chk("arst_det", -1, 32'(det_mask), 0);
    chk("arst_terr", -1, 32'(timeout_err), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", -1, 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_det_sched.md
# rx_det_sched

Receiver-detect scheduler for the 4-lane LTSSM. On a start pulse from `core_fsm` it runs the shared analog detect circuit one lane at a time. Each lane is driven through a four-phase `rx_det_seq_req`/`rx_det_seq_ack` handshake. The scheduler runs two detect passes, with per-lane ack timeouts, and returns a confirmed detected-lane mask. This mask is the Detect.Active input to the lane-configuration logic.

## Interface
- `NUM_LANES`, 4: lanes scheduled, lane 0 first.
- `ACK_TIMEOUT`, 64: maximum cycles spent waiting in either handshake phase.
- `SETTLE_CYCLES`, 16: cycles between ack release and sampling `rx_det`; minimum 1.
- `clk`, in, 1: 1 GHz system clock.
- `rst`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: single-cycle request to run detection; ignored while `busy`.
- `abort`, in, 1: level; cancels the run.
- `rx_det_seq_req`, out, NUM_LANES: per-lane detect request; at most one bit high.
- `rx_det_seq_ack`, in, NUM_LANES: per-lane detect acknowledge.
- `rx_det`, in, NUM_LANES: per-lane detect result; valid only at the sample point.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a run completes.
- `det_mask`, out, NUM_LANES: lanes detected in both passes; valid from `done` until the next `start`.
- `timeout_err`, out, NUM_LANES: lanes that timed out in any pass; valid with `det_mask`.

## Operation
- States: IDLE, REQ, REL, SETTLE, NEXT, DONE. Registers:
  - `lane` index
  - `pass` bit
  - shared cycle counter, width `$clog2(max(ACK_TIMEOUT,SETTLE_CYCLES)+1)`
  - `p0_mask`, `p1_mask`, `err` (NUM_LANES each)
- IDLE:
  - `start`=1 moves to REQ with lane=0 and pass=0.
  - Clears `p0_mask`, `p1_mask`, `err`, `det_mask` and `timeout_err`.
- REQ:
  - Drives `rx_det_seq_req[lane]`=1; the counter increments every cycle.
  - Ack[lane]=1 moves to REL and clears the counter.
  - Counter reaching ACK_TIMEOUT with ack still low: set `err[lane]`, go to NEXT.
- REL:
  - req=0. Ack[lane]=0 moves to SETTLE and clears the counter.
  - ACK_TIMEOUT expiry: set `err[lane]`, go to NEXT.
- SETTLE:
  - Counter counts to SETTLE_CYCLES.
  - On the terminal cycle, sample `rx_det[lane]` into `p0_mask[lane]` (pass 0) or `p1_mask[lane]` (pass 1), then go to NEXT.
- NEXT selects the next lane to test:
  - In pass 1 only lanes with `p0_mask`=1 and `err`=0 are tested.
  - If no remaining lane is eligible in the current pass: from pass 0, go to pass 1 at the lowest eligible lane. If `p0_mask & ~err` is zero, skip pass 1 and go to DONE. From pass 1, go to DONE.
- DONE:
  - `det_mask` <= `p0_mask & p1_mask & ~err`; `timeout_err` <= `err`.
  - `done`=1 for this single cycle, then return to IDLE.
- Acks on lanes other than `lane` are ignored. An ack[lane] already high on entry to REQ is accepted immediately.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; all req bits low next cycle.
  - No `done` pulse.
  - `det_mask` and `timeout_err` are cleared.
  - `abort` takes priority over `start` in the same cycle.
- `start` and `abort` both high in IDLE: remain in IDLE.

## Timing
- Reset values: `rx_det_seq_req`=0, `busy`=0, `done`=0, `det_mask`=0, `timeout_err`=0, state IDLE.
- All outputs are registered. Each req bit is a direct flop (no decode glitch).
- `start` sampled at edge S: `req[0]` and `busy` are high after S.
- Per-lane cost with an ack that follows req by one registered cycle in each direction: 5+SETTLE_CYCLES cycles, i.e. 21 cycles at default.
- Timed-out lane: ACK_TIMEOUT+1 cycles in REQ, plus 1 cycle in NEXT.
- Full run, all lanes detected, defaults: 8 lanes-tests × 21 = 168 cycles. `done` is high in the cycle after edge S+168, and `busy` falls one cycle later.
- `det_mask` updates on the same edge that raises `done`.

## Test plan
- All 4 lanes ack after 1 cycle; `rx_det`=4'b1111 -> req pulses in order lane0..3 twice; `done` at S+168; `det_mask`=4'b1111; `timeout_err`=0.
- `rx_det`=4'b0101 in both passes -> pass 1 requests only lanes 0 and 2; `done` at S+84+42=S+126; `det_mask`=4'b0101.
- Lane 2 never acks, others detected -> `req[2]` high for 65 cycles, then dropped; `timeout_err`=4'b0100; `det_mask`=4'b1011; lane 2 not requested in pass 1.
- `rx_det`=4'b0000 -> pass 1 skipped; `done` at S+84; `det_mask`=0.
- Lane 1 detected in pass 0, not in pass 1 -> `det_mask[1]`=0.
- `abort` while in SETTLE of lane 1 -> req all 0 and `busy`=0 next cycle; no `done`; a new `start` reruns cleanly from lane 0.
- `rst` asserted mid-REQ -> req and all outputs 0 immediately (asynchronous); `start` during `busy` ignored.
